// File: rtl/sdram_clk_phase_gen_if.sv
// Configuration write port of the SDRAM/PHY clock phase generator.
// The master issues strobed channel writes; the slave returns a one-cycle ack.
interface sdram_clk_phase_gen_if #(
  parameter int CH_WIDTH  = 3,
  parameter int DIV_WIDTH = 8
) ();
  logic                 cfg_stb;
  logic [CH_WIDTH-1:0]  cfg_ch;
  logic [DIV_WIDTH-1:0] cfg_div;
  logic [DIV_WIDTH-1:0] cfg_phase;
  logic                 cfg_ack;

  modport master (
    output cfg_stb, cfg_ch, cfg_div, cfg_phase,
    input  cfg_ack
  );

  modport slave (
    input  cfg_stb, cfg_ch, cfg_div, cfg_phase,
    output cfg_ack
  );
endinterface

// File: rtl/sdram_clk_phase_gen.sv
// Multi-channel divided clock / strobe generator with a lock sequencer.
// All channels are held at their phase offset while LOCKING and run together in RUN.
module sdram_clk_phase_gen #(
  parameter int CHANNELS    = 2,
  parameter int DIV_WIDTH   = 8,
  parameter int DEFAULT_DIV = 2,
  parameter int LOCK_CYCLES = 16,
  parameter int CH_WIDTH    = 3
) (
  input  logic                clk,
  input  logic                rst,
  sdram_clk_phase_gen_if.slave cfg,
  output logic                locked,
  output logic [CHANNELS-1:0] clk_out,
  output logic [CHANNELS-1:0] clk_en
);

  localparam int LW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  typedef logic [DIV_WIDTH-1:0] dw_t;
  typedef enum logic {LOCKING, RUN} state_t;

  state_t          state, state_nxt;
  logic [LW-1:0]   lock_cnt, lock_nxt;
  dw_t             div_r   [CHANNELS];
  dw_t             phase_r [CHANNELS];
  dw_t             cnt     [CHANNELS];
  dw_t             div_nxt   [CHANNELS];
  dw_t             phase_nxt [CHANNELS];
  dw_t             cnt_nxt   [CHANNELS];
  logic            wr_valid;
  logic            run_nxt;
  logic [CHANNELS-1:0] out_nxt;
  logic [CHANNELS-1:0] en_nxt;

  // Divide ratios below 2 cannot form a clock, so they run as 2.
  function automatic dw_t eff_div(input dw_t d);
    return (d < dw_t'(2)) ? dw_t'(2) : d;
  endfunction

  function automatic dw_t eff_phase(input dw_t p, input dw_t de);
    return (p >= de) ? (de - dw_t'(1)) : p;
  endfunction

  always_comb begin
    wr_valid  = cfg.cfg_stb && (int'(cfg.cfg_ch) < CHANNELS);
    state_nxt = state;
    lock_nxt  = lock_cnt;
    run_nxt   = 1'b0;
    out_nxt   = '0;
    en_nxt    = '0;

    if (state == LOCKING) begin
      if (lock_cnt == LW'(LOCK_CYCLES - 1))
        state_nxt = RUN;
      else
        lock_nxt = lock_cnt + LW'(1);
    end

    for (int i = 0; i < CHANNELS; i++) begin
      div_nxt[i]   = div_r[i];
      phase_nxt[i] = phase_r[i];
      if (state == LOCKING || wr_valid)
        cnt_nxt[i] = eff_phase(phase_r[i], eff_div(div_r[i]));
      else if (cnt[i] == eff_div(div_r[i]) - dw_t'(1))
        cnt_nxt[i] = '0;
      else
        cnt_nxt[i] = cnt[i] + dw_t'(1);
      if (wr_valid && cfg.cfg_ch == CH_WIDTH'(i)) begin
        div_nxt[i]   = cfg.cfg_div;
        phase_nxt[i] = cfg.cfg_phase;
      end
    end

    // Any accepted write relocks every channel so relative phases stay aligned.
    if (wr_valid) begin
      state_nxt = LOCKING;
      lock_nxt  = '0;
    end

    run_nxt = (state_nxt == RUN);
    for (int i = 0; i < CHANNELS; i++) begin
      out_nxt[i] = run_nxt && (cnt_nxt[i] < (eff_div(div_nxt[i]) >> 1));
      en_nxt[i]  = run_nxt && (cnt_nxt[i] == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= LOCKING;
      lock_cnt    <= '0;
      locked      <= 1'b0;
      clk_out     <= '0;
      clk_en      <= '0;
      cfg.cfg_ack <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        div_r[i]   <= dw_t'(DEFAULT_DIV);
        phase_r[i] <= '0;
        cnt[i]     <= '0;
      end
    end else begin
      state       <= state_nxt;
      lock_cnt    <= lock_nxt;
      locked      <= run_nxt;
      clk_out     <= out_nxt;
      clk_en      <= en_nxt;
      cfg.cfg_ack <= cfg.cfg_stb;
      for (int i = 0; i < CHANNELS; i++) begin
        div_r[i]   <= div_nxt[i];
        phase_r[i] <= phase_nxt[i];
        cnt[i]     <= cnt_nxt[i];
      end
    end
  end

endmodule
